// File: rtl/gcd_unit.sv
// gcd_unit: single-job Euclid GCD worker (subtract/swap iteration).
// It accepts an operand pair on the request handshake and computes the GCD.
// The result is held on the response port until the response handshake completes.
module gcd_unit #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          request_val,
  input  logic [W-1:0]  request_operands_bits_A,
  input  logic [W-1:0]  request_operands_bits_B,
  output logic          request_rdy,
  output logic          response_val,
  output logic [W-1:0]  response_result_bits_data,
  input  logic          response_rdy,
  output logic          busy,
  output logic [CW-1:0] jobs_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] JOBS_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] JOBS_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  a_nxt_s;
  logic [W-1:0]  b_nxt_s;
  logic [CW-1:0] jobs_r;
  logic [CW-1:0] jobs_nxt_s;
  logic          req_fire_s;
  logic          resp_fire_s;

  // Port views of the state. request_rdy is masked by reset so that no
  // request can be accepted while reset is held high.
  assign request_rdy               = (state_r == IDLE) & ~reset;
  assign response_val              = (state_r == DONE);
  assign busy                      = (state_r != IDLE);
  assign response_result_bits_data = a_r;
  assign jobs_done                 = jobs_r;

  assign req_fire_s  = request_val & request_rdy;
  assign resp_fire_s = response_val & response_rdy;

  // Next-state logic: accept a job, iterate Euclid one step per cycle, and release the result.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    jobs_nxt_s  = jobs_r;
    case (state_r)
      IDLE: begin
        if (req_fire_s) begin
          a_nxt_s     = request_operands_bits_A;
          b_nxt_s     = request_operands_bits_B;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (b_r == ZERO_W) begin
          // A already holds the result; freeze it for the response.
          state_nxt_s = DONE;
        end else if (a_r < b_r) begin
          a_nxt_s = b_r;
          b_nxt_s = a_r;
        end else begin
          // A >= B here, so the subtraction cannot wrap.
          a_nxt_s = a_r - b_r;
        end
      end
      DONE: begin
        if (resp_fire_s) begin
          state_nxt_s = IDLE;
          if (jobs_r != JOBS_MAX) begin
            jobs_nxt_s = jobs_r + JOBS_ONE;
          end else begin
            jobs_nxt_s = jobs_r;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        // An unreachable encoding falls back to IDLE.
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight and clears the job counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= ZERO_W;
      b_r     <= ZERO_W;
      jobs_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      jobs_r  <= jobs_nxt_s;
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed self-checking bench for gcd_unit.
// u0 uses the default widths (W=32, CW=16). u1 uses W=8 and CW=2, which
// exercises counter saturation and the longest subtraction run.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        request_val;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        request_rdy;
  logic        response_val;
  logic [31:0] resp_data;
  logic        response_rdy;
  logic        busy;
  logic [15:0] jobs_done;

  logic        s_request_val;
  logic [7:0]  s_req_a;
  logic [7:0]  s_req_b;
  logic        s_request_rdy;
  logic        s_response_val;
  logic [7:0]  s_resp_data;
  logic        s_response_rdy;
  logic        s_busy;
  logic [1:0]  s_jobs_done;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_jobs = 0;
  int edges;

  logic [31:0] ja [3] = '{32'd12, 32'd35, 32'd17};
  logic [31:0] jb [3] = '{32'd8,  32'd14, 32'd5};
  logic [31:0] je [3] = '{32'd4,  32'd7,  32'd1};

  gcd_unit #(.W(32), .CW(16)) u0 (
    .clk                       (clk),
    .reset                     (reset),
    .request_val               (request_val),
    .request_operands_bits_A   (req_a),
    .request_operands_bits_B   (req_b),
    .request_rdy               (request_rdy),
    .response_val              (response_val),
    .response_result_bits_data (resp_data),
    .response_rdy              (response_rdy),
    .busy                      (busy),
    .jobs_done                 (jobs_done)
  );

  gcd_unit #(.W(8), .CW(2)) u1 (
    .clk                       (clk),
    .reset                     (reset),
    .request_val               (s_request_val),
    .request_operands_bits_A   (s_req_a),
    .request_operands_bits_B   (s_req_b),
    .request_rdy               (s_request_rdy),
    .response_val              (s_response_val),
    .response_result_bits_data (s_resp_data),
    .response_rdy              (s_response_rdy),
    .busy                      (s_busy),
    .jobs_done                 (s_jobs_done)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One job on u0. Latency is counted in cycles from the fire cycle to the
  // first cycle with response_val high, i.e. 1 + number of CALC cycles.
  task automatic job0(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int exp_lat, input int hold);
    int n;
    req_a = a; req_b = b; request_val = 1'b1; response_rdy = 1'b0;
    tick;
    request_val = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_rdy_calc"}, request_rdy, 1'b0);
    n = 0;
    while (!response_val && n < 2000) begin
      tick;
      n++;
    end
    chk({tag, "_val"}, response_val, 1'b1);
    if (exp_lat > 0) chk({tag, "_lat"}, n + 1, exp_lat);
    chk({tag, "_data"}, resp_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_val"}, response_val, 1'b1);
      chk({tag, "_hold_data"}, resp_data, exp);
    end
    response_rdy = 1'b1;
    tick;
    response_rdy = 1'b0;
    exp_jobs++;
    chk({tag, "_idle_rdy"}, request_rdy, 1'b1);
    chk({tag, "_idle_val"}, response_val, 1'b0);
    chk({tag, "_jobs"}, jobs_done, exp_jobs);
  endtask

  // One job on u1, with the expected saturated counter value afterwards.
  task automatic job1(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int exp_lat, input logic [1:0] exp_jd);
    int n;
    s_req_a = a; s_req_b = b; s_request_val = 1'b1; s_response_rdy = 1'b0;
    tick;
    s_request_val = 1'b0;
    n = 0;
    while (!s_response_val && n < 2000) begin
      tick;
      n++;
    end
    chk({tag, "_val"}, s_response_val, 1'b1);
    if (exp_lat > 0) chk({tag, "_lat"}, n + 1, exp_lat);
    chk({tag, "_data"}, s_resp_data, exp);
    s_response_rdy = 1'b1;
    tick;
    s_response_rdy = 1'b0;
    chk({tag, "_jobs"}, s_jobs_done, exp_jd);
    chk({tag, "_busy"}, s_busy, 1'b0);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    request_val = 1'b0; req_a = 32'd0; req_b = 32'd0; response_rdy = 1'b0;
    s_request_val = 1'b0; s_req_a = 8'd0; s_req_b = 8'd0; s_response_rdy = 1'b0;
    tick;
    chk("rst_rdy_low", request_rdy, 1'b0);
    tick;
    chk("rst_val", response_val, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_jobs", jobs_done, 16'd0);
    reset = 1'b0;
    #1;
    chk("idle_rdy", request_rdy, 1'b1);

    // A response_rdy held high while idle must have no effect.
    response_rdy = 1'b1;
    tick; tick;
    chk("idle_rsp_busy", busy, 1'b0);
    chk("idle_rsp_val", response_val, 1'b0);
    chk("idle_rsp_jobs", jobs_done, 16'd0);
    response_rdy = 1'b0;

    // Basic job, with the result held stable for 5 cycles.
    job0("basic", 32'd27, 32'd15, 32'd3, 11, 5);

    // Edge operands.
    job0("z_z", 32'd0, 32'd0, 32'd0, 2, 0);
    job0("x_z", 32'd9, 32'd0, 32'd9, 2, 0);
    job0("z_x", 32'd0, 32'd9, 32'd9, 3, 0);
    job0("eq",  32'd7, 32'd7, 32'd7, 4, 0);

    // Back-to-back jobs with request_val and response_rdy tied high.
    req_a = ja[0]; req_b = jb[0]; request_val = 1'b1; response_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      if (j < 2) begin
        req_a = ja[j+1]; req_b = jb[j+1];
      end
      chk("b2b_rdy_calc", request_rdy, 1'b0);
      edges = 0;
      while (!response_val && edges < 200) begin
        tick;
        edges++;
        chk("b2b_rdy_busy", request_rdy, 1'b0);
      end
      chk("b2b_val", response_val, 1'b1);
      chk("b2b_data", resp_data, je[j]);
      tick;
      if (j == 2) request_val = 1'b0;
      exp_jobs++;
      chk("b2b_rdy_idle", request_rdy, 1'b1);
      chk("b2b_jobs", jobs_done, exp_jobs);
    end
    response_rdy = 1'b0;
    tick;
    chk("b2b_end_busy", busy, 1'b0);

    // Reset in the middle of a long computation aborts the job.
    req_a = 32'd1000; req_b = 32'd1; request_val = 1'b1;
    tick;
    request_val = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick;
      chk("abort_no_val", response_val, 1'b0);
    end
    chk("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick;
    chk("abort_busy", busy, 1'b0);
    chk("abort_val", response_val, 1'b0);
    chk("abort_rdy_rst", request_rdy, 1'b0);
    chk("abort_jobs", jobs_done, 16'd0);
    reset = 1'b0;
    exp_jobs = 0;
    #1;
    chk("abort_rdy", request_rdy, 1'b1);
    job0("after_abort", 32'd6, 32'd4, 32'd2, 7, 0);

    // Counter saturation on the narrow instance.
    chk("sat_start", s_jobs_done, 2'd0);
    job1("sat1", 8'd4, 8'd2, 8'd2, 5, 2'd1);
    job1("sat2", 8'd4, 8'd2, 8'd2, 5, 2'd2);
    job1("sat3", 8'd4, 8'd2, 8'd2, 5, 2'd3);
    job1("sat4", 8'd4, 8'd2, 8'd2, 5, 2'd3);
    job1("sat5", 8'd4, 8'd2, 8'd2, 5, 2'd3);
    // 255 subtractions, one swap, then the terminating B==0 cycle.
    job1("max", 8'd255, 8'd1, 8'd1, 258, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
Single GCD worker and the responder end of the arbiter's request/response interface. It accepts one operand pair per request handshake and computes the GCD iteratively with Euclid subtraction/swap. It holds the result until the response handshake completes. N instances sit behind the GCD arbiter, one per request/response lane; results return in order because each unit holds exactly one job.

Parameters:
W, 32, operand and result width in bits
CW, 16, width of the completed-job counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
request_val  input  1  arbiter presents a valid operand pair
request_operands_bits_A  input  W  operand A
request_operands_bits_B  input  W  operand B
request_rdy  output  1  unit idle and able to accept a request
response_val  output  1  result valid
response_result_bits_data  output  W  GCD result
response_rdy  input  1  arbiter takes the result
busy  output  1  unit holds a job (CALC or DONE)
jobs_done  output  CW  saturating count of completed response handshakes

Behaviour:
- One clock, named clk. Reset is synchronous and active-high, named reset; the polarity and synchronicity are fixed.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: result held.
- Reset values:
  - State IDLE, internal registers A and B = 0, jobs_done = 0.
  - response_val = 0, response_result_bits_data = 0, busy = 0.
  - request_rdy = 0 while reset is high.
- Outputs per state:
  - request_rdy = (state==IDLE) & !reset.
  - response_val = (state==DONE).
  - busy = (state!=IDLE).
- Request fire = request_val & request_rdy. On fire: A <= operand A, B <= operand B, state <= CALC. No fire means IDLE holds.
- request_val is ignored outside IDLE. It is never stored or queued.
- In CALC, exactly one action per cycle, in priority order:
  1. B==0: state <= DONE; A holds the result.
  2. A<B (unsigned): swap A and B.
  3. Otherwise: A <= A-B.
- All arithmetic is unsigned and W bits wide. Subtraction never underflows because A>=B is guaranteed.
- In DONE, response_result_bits_data = A, stable until the handshake completes.
- Response fire = response_val & response_rdy. On fire: state <= IDLE and jobs_done increments, saturating at 2^CW-1.
- response_rdy is ignored outside DONE.
- Latency: request fire at cycle t, first CALC cycle is t+1, response_val rises at t+1+k, where k = number of CALC cycles including the terminating B==0 cycle. Minimum fire-to-response_val is 2 cycles.
- Back-to-back jobs: request_rdy rises the cycle after response fire. There is no same-cycle response/request overlap.
- Special cases:
  - gcd(0,0) = 0.
  - gcd(x,0) = x.
  - gcd(0,x) = x, via one swap.
- Reset in CALC or DONE aborts the job: state returns to IDLE, the result is discarded, and jobs_done clears.
- response_result_bits_data in IDLE/CALC is don't-care for protocol. Implementation drives A.

Test Plan:
- Reset, then idle: reset high 2 cycles, low -> request_rdy=1, response_val=0, busy=0, jobs_done=0. Holding response_rdy=1 does nothing.
- Basic job: fire (27,15) at cycle 0 -> CALC for 10 cycles, response_val=1 at cycle 11 with data=3. Holding response_rdy=0 for 5 cycles keeps data=3 stable. Asserting response_rdy -> IDLE next cycle, jobs_done=1.
- Edge operands:
  - (0,0) -> 0 at cycle 2.
  - (9,0) -> 9 at cycle 2.
  - (0,9) -> 9 at cycle 3.
  - (7,7) -> 7.
- Back-to-back with response_rdy tied high and request_val tied high, jobs (12,8), (35,14), (17,5) -> results 4, 7, 1 in order. request_rdy is 0 throughout CALC/DONE. jobs_done=3.
- Reset mid-CALC: fire (1000,1) (long run), assert reset at cycle 50 -> IDLE next cycle, response_val never asserts. A new job (6,4) then returns 2.
- Saturation with CW=2: 5 completed jobs -> jobs_done sticks at 3. Max operands (2^W-1, 1) -> 1 after 2^W-1 subtraction cycles; run with W=8 to check the 255 subtraction cycles.
